// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer.
// Contents: ALU control codes, sequencer FSM state encoding, command word width helper.
package alu_seq_pkg;

    localparam int unsigned OP_W = 3;

    // ALU control codes presented on alu_crl
    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_NOT = 3'd2;
    localparam logic [OP_W-1:0] OP_AND = 3'd3;
    localparam logic [OP_W-1:0] OP_OR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR = 3'd5;
    localparam logic [OP_W-1:0] OP_LT  = 3'd6;
    localparam logic [OP_W-1:0] OP_EQ  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } seq_state_t;

    // Command word is {op, a, b}
    function automatic int unsigned cmd_width(input int unsigned w);
        return 2 * w + OP_W;
    endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous command FIFO for the ALU sequencer.
// Ports: clk, rst_n (async active-low); push/wdata write side; pop/rdata read side
// (rdata shows the head entry); full/empty status. Push on full and pop on empty are ignored.
module alu_seq_fifo
    import alu_seq_pkg::*;
#(
    parameter int unsigned DW    = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage, no reset needed: contents are only read behind a valid pointer
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: queues commands, drives a combinational ALU one command at a
// time, waits ALU_LAT cycles, captures result/flags and offers them downstream.
// Ports: cmd_* upstream valid/ready command port; alu_a/alu_b/alu_crl registered ALU
// operands/ctrl; alu_result/alu_carry/alu_overflow/alu_zero ALU outputs; rsp_* downstream
// valid/ready response port; busy = work queued or in flight.
// Optional: define ALU_SEQ_STICKY_FLAGS_EN to add sticky_clr/sticky_carry/sticky_ovf.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned ALU_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_crl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_op,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic             busy
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    ,
    input  logic             sticky_clr,
    output logic             sticky_carry,
    output logic             sticky_ovf
`endif
);

    localparam int unsigned CMD_W = cmd_width(WIDTH);
    localparam int unsigned CNT_W = $clog2(ALU_LAT + 1);

    seq_state_t       state;
    logic [CNT_W-1:0] wait_cnt;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_wdata;
    logic [CMD_W-1:0] fifo_rdata;
    logic             push_c;
    logic             pop_c;
    logic             capture_c;
    logic [2:0]       head_op;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;

    assign cmd_ready  = !fifo_full;
    assign push_c     = cmd_valid && !fifo_full;
    assign fifo_wdata = {cmd_op, cmd_a, cmd_b};

    assign head_op = fifo_rdata[CMD_W-1 -: 3];
    assign head_a  = fifo_rdata[2*WIDTH-1 -: WIDTH];
    assign head_b  = fifo_rdata[WIDTH-1:0];

    // Pop only from registered FIFO state, so a same-cycle push into an empty FIFO waits
    assign pop_c = !fifo_empty &&
                   ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));

    assign capture_c = (state == ST_DRIVE) && (wait_cnt == CNT_W'(1));
    assign busy      = !fifo_empty || (state != ST_IDLE);

    alu_seq_fifo #(
        .DW    (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .wdata (fifo_wdata),
        .pop   (pop_c),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sequencer FSM with registered ALU drive and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_crl      <= '0;
            rsp_valid    <= 1'b0;
            rsp_op       <= '0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        alu_a    <= head_a;
                        alu_b    <= head_b;
                        alu_crl  <= head_op;
                        wait_cnt <= CNT_W'(ALU_LAT);
                        state    <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    if (capture_c) begin
                        rsp_op       <= alu_crl;
                        rsp_result   <= alu_result;
                        rsp_carry    <= alu_carry;
                        rsp_overflow <= alu_overflow;
                        rsp_zero     <= alu_zero;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (pop_c) begin
                            alu_a    <= head_a;
                            alu_b    <= head_b;
                            alu_crl  <= head_op;
                            wait_cnt <= CNT_W'(ALU_LAT);
                            state    <= ST_DRIVE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    // Sticky flags: a capture in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_carry <= 1'b0;
            sticky_ovf   <= 1'b0;
        end else begin
            sticky_carry <= (sticky_carry & ~sticky_clr) | (capture_c & alu_carry);
            sticky_ovf   <= (sticky_ovf & ~sticky_clr) | (capture_c & alu_overflow);
        end
    end
`endif

endmodule
